// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - registered RV32I decode stage producing ALU control, immediate and register indices
//
// Optional feature macro: ALU_DECODE_ILLEGAL_EN (illegal flag and saturating illegal counter).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake; in_instr, in_pc carried with it
//   flush               drops the held word and blocks any same-cycle accept
//   out_valid/out_ready output handshake for the single-entry output register
//   alu_op, a_sel, b_sel, imm, rs1, rs2, rd, reg_wr, pc_out   decoded word
//   illegal, illegal_cnt  illegal-word flag and saturating count of accepted illegal words

module alu_op_decoder #(
  parameter int IMM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [IMM_W-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic             a_sel,
  output logic             b_sel,
  output logic [IMM_W-1:0] imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             reg_wr,
  output logic [IMM_W-1:0] pc_out,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // funct3 -> ALU code; alt selects sub (funct3=000) or sra (funct3=101)
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = 4'd1;
      3'b010:  alu_map = 4'd2;
      3'b011:  alu_map = 4'd3;
      3'b100:  alu_map = 4'd4;
      3'b101:  alu_map = alt ? 4'd6 : 4'd5;
      3'b110:  alu_map = 4'd7;
      default: alu_map = 4'd8;
    endcase
  endfunction

  logic [3:0]  op_d;
  logic        a_sel_d, b_sel_d, reg_wr_d, ill_d;
  logic [31:0] imm32_d;

  always_comb begin
    op_d     = ALU_ADD;
    a_sel_d  = 1'b0;
    b_sel_d  = 1'b0;
    reg_wr_d = 1'b0;
    imm32_d  = 32'd0;
    ill_d    = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_wr_d = 1'b1;
        op_d     = alu_map(funct3, in_instr[30]);
        // funct7=0x20 is only meaningful for sub and sra
        ill_d    = !((funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        b_sel_d  = 1'b1;
        reg_wr_d = 1'b1;
        imm32_d  = imm_i;
        // funct3=000 carries an immediate in instr[30], never a sub
        op_d     = alu_map(funct3, (funct3 == 3'b101) && in_instr[30]);
        if (funct3 == 3'b001)
          ill_d = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          ill_d = !((funct7 == 7'h00) || (funct7 == 7'h20));
      end
      OPC_LUI: begin
        op_d     = ALU_PASS;
        b_sel_d  = 1'b1;
        reg_wr_d = 1'b1;
        imm32_d  = imm_u;
      end
      OPC_AUIPC: begin
        a_sel_d  = 1'b1;
        b_sel_d  = 1'b1;
        reg_wr_d = 1'b1;
        imm32_d  = imm_u;
      end
      OPC_LOAD, OPC_JALR: begin
        b_sel_d  = 1'b1;
        reg_wr_d = 1'b1;
        imm32_d  = imm_i;
      end
      OPC_STORE: begin
        b_sel_d  = 1'b1;
        imm32_d  = imm_s;
      end
      OPC_BRANCH: begin
        op_d     = ALU_SUB;
        imm32_d  = imm_b;
      end
      OPC_JAL: begin
        a_sel_d  = 1'b1;
        b_sel_d  = 1'b1;
        reg_wr_d = 1'b1;
        imm32_d  = imm_j;
      end
      default: ill_d = 1'b1;
    endcase
    // illegal words decode to a harmless NOP regardless of the feature macro
    if (ill_d) begin
      op_d     = ALU_ADD;
      a_sel_d  = 1'b0;
      b_sel_d  = 1'b0;
      reg_wr_d = 1'b0;
      imm32_d  = 32'd0;
    end
  end

  logic accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_op    <= 4'd0;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      imm       <= '0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
      reg_wr    <= 1'b0;
      pc_out    <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (accept)
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (accept) begin
        alu_op <= op_d;
        a_sel  <= a_sel_d;
        b_sel  <= b_sel_d;
        imm    <= IMM_W'(signed'(imm32_d));
        rs1    <= in_instr[19:15];
        rs2    <= in_instr[24:20];
        rd     <= in_instr[11:7];
        reg_wr <= reg_wr_d;
        pc_out <= in_pc;
      end
    end
  end

`ifdef ALU_DECODE_ILLEGAL_EN
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      illegal_q <= ill_d;
      if (ill_d && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;
`else
  assign illegal     = 1'b0;
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - directed-vector bench for alu_op_decoder

module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        a_sel;
  logic        b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_wr;
  logic [31:0] pc_out;
  logic        illegal;
  logic [15:0] illegal_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_decoder #(.IMM_W(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_op      (alu_op),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .imm         (imm),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .reg_wr      (reg_wr),
    .pc_out      (pc_out),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic exp_word(input string tag, input logic [3:0] op, input logic as, input logic bs,
                          input logic [31:0] im, input logic [4:0] d, input logic wr);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".alu_op"}, alu_op, op);
    chk({tag, ".a_sel"}, a_sel, as);
    chk({tag, ".b_sel"}, b_sel, bs);
    chk({tag, ".imm"}, imm, im);
    chk({tag, ".rd"}, rd, d);
    chk({tag, ".reg_wr"}, reg_wr, wr);
  endtask

  logic        ill_exp;
  logic [15:0] cnt_exp;

  initial begin
`ifdef ALU_DECODE_ILLEGAL_EN
    ill_exp = 1'b1;
`else
    ill_exp = 1'b0;
`endif
    cnt_exp   = 16'd0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    step();
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.alu_op", alu_op, 4'd0);
    chk("rst.imm", imm, 32'd0);
    chk("rst.illegal", illegal, 1'b0);
    chk("rst.cnt", illegal_cnt, 16'd0);
    rst_n = 1'b1;
    step();

    drive(1'b1, 32'h40208033, 32'h100);
    step();
    exp_word("sub", 4'd9, 1'b0, 1'b0, 32'd0, 5'd0, 1'b1);
    chk("sub.rs1", rs1, 5'd1);
    chk("sub.rs2", rs2, 5'd2);
    chk("sub.pc", pc_out, 32'h100);

    drive(1'b1, 32'hFFF0A093, 32'h104);
    step();
    exp_word("slti", 4'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd1, 1'b1);
    chk("slti.illegal", illegal, 1'b0);

    drive(1'b1, 32'h4010D093, 32'h108);
    step();
    exp_word("srai", 4'd6, 1'b0, 1'b1, 32'h401, 5'd1, 1'b1);

    // backpressure: next word waits while outputs hold
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h10C);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", in_ready, 1'b0);
      step();
      chk("bp.hold_op", alu_op, 4'd6);
      chk("bp.hold_imm", imm, 32'h401);
      chk("bp.hold_pc", pc_out, 32'h108);
      chk("bp.valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", in_ready, 1'b1);
    step();
    exp_word("add", 4'd0, 1'b0, 1'b0, 32'd0, 5'd3, 1'b1);
    drive(1'b1, 32'h0020F233, 32'h110);
    step();
    exp_word("and", 4'd8, 1'b0, 1'b0, 32'd0, 5'd4, 1'b1);

    drive(1'b1, 32'h00208463, 32'h114);
    step();
    exp_word("beq", 4'd9, 1'b0, 1'b0, 32'd8, 5'd8, 1'b0);
    drive(1'b1, 32'hFE20AE23, 32'h118);
    step();
    exp_word("sw", 4'd0, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd28, 1'b0);
    drive(1'b1, 32'hFFFFF0EF, 32'h11C);
    step();
    exp_word("jal", 4'd0, 1'b1, 1'b1, 32'hFFFFFFFE, 5'd1, 1'b1);
    drive(1'b1, 32'h00001097, 32'h120);
    step();
    exp_word("auipc", 4'd0, 1'b1, 1'b1, 32'h1000, 5'd1, 1'b1);

    // lui, then flush with a pending accept that must not load
    drive(1'b1, 32'h12345037, 32'h124);
    step();
    exp_word("lui", 4'd10, 1'b0, 1'b1, 32'h12345000, 5'd0, 1'b1);
    flush = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h128);
    step();
    chk("flush.valid", out_valid, 1'b0);
    chk("flush.no_load_op", alu_op, 4'd10);
    chk("flush.no_load_pc", pc_out, 32'h124);
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    step();
    chk("flush.after", out_valid, 1'b0);

    // flush drops a stalled word
    drive(1'b1, 32'h12345037, 32'h12C);
    step();
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    step();
    chk("flush.held", out_valid, 1'b0);
    flush     = 1'b0;
    out_ready = 1'b1;

    // illegal opcode twice
    drive(1'b1, 32'h0000007F, 32'h200);
    step();
    drive(1'b1, 32'h0000007F, 32'h204);
    step();
    if (ill_exp) cnt_exp = 16'd2;
    chk("ill.valid", out_valid, 1'b1);
    chk("ill.flag", illegal, ill_exp);
    chk("ill.cnt", illegal_cnt, cnt_exp);
    chk("ill.reg_wr", reg_wr, 1'b0);
    chk("ill.alu_op", alu_op, 4'd0);
    chk("ill.imm", imm, 32'd0);

    // sll with funct7=0x20 is illegal; fields fall to NOP
    drive(1'b1, 32'h40209033, 32'h208);
    step();
    if (ill_exp) cnt_exp = 16'd3;
    chk("ill_op.flag", illegal, ill_exp);
    chk("ill_op.cnt", illegal_cnt, cnt_exp);
    chk("ill_op.reg_wr", reg_wr, 1'b0);
    chk("ill_op.alu_op", alu_op, 4'd0);

    // legal word clears the flag, counter unchanged
    drive(1'b1, 32'h002081B3, 32'h20C);
    step();
    chk("legal.flag", illegal, 1'b0);
    chk("legal.cnt", illegal_cnt, cnt_exp);

`ifdef ALU_DECODE_ILLEGAL_EN
    drive(1'b1, 32'h0000007F, 32'h300);
    for (int i = 0; i < 65530; i++) step();
    chk("sat.near", illegal_cnt, 16'hFFFD);
    for (int i = 0; i < 6; i++) step();
    chk("sat.hold", illegal_cnt, 16'hFFFF);
    step();
    chk("sat.no_wrap", illegal_cnt, 16'hFFFF);
`else
    drive(1'b1, 32'h0000007F, 32'h300);
    for (int i = 0; i < 20; i++) step();
    chk("noill.cnt", illegal_cnt, 16'd0);
    chk("noill.flag", illegal, 1'b0);
`endif

    // asynchronous reset mid-transfer, away from any clock edge
    out_ready = 1'b0;
    drive(1'b1, 32'h12345037, 32'h400);
    step();
    drive(1'b0, 32'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", out_valid, 1'b0);
    chk("arst.in_ready", in_ready, 1'b1);
    chk("arst.alu_op", alu_op, 4'd0);
    chk("arst.cnt", illegal_cnt, 16'd0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
